// File: rtl/light_judge.sv
`default_nettype none
// ============================================================================
//  Module      : light_judge
//  Description : Game judge for the light-sweep counter. Decodes the light
//                position to LEDs, judges key presses against a target
//                position, keeps score and lives, and serves the counter.
//  Revision    : 1.0  initial release
// ============================================================================
module light_judge #(
    parameter int TARGET  = 4,
    parameter int SCORE_W = 4,
    parameter int LIVES   = 3
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic [2:0]         pos,
    input  logic               key,
    output logic               start,
    output logic [4:0]         leds,
    output logic               hit,
    output logic               miss,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over
);

    localparam logic [2:0]         c_target    = 3'(TARGET);
    localparam logic [1:0]         c_lives     = 2'(LIVES);
    localparam logic [SCORE_W-1:0] c_score_max = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_SWEEP = 2'd2,
        S_OVER  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nx;
    logic   r_key_d;
    logic   r_pressed;

    logic   w_rest;
    logic   w_key_rise;
    logic   w_do_hit;
    logic   w_do_miss;
    logic   w_set_pressed;
    logic   w_clr_pressed;
    logic   w_restart;

    // Positions 5..7 all mean "rest"; only 0..4 light an LED.
    assign w_rest     = (pos >= 3'd5);
    assign w_key_rise = key & ~r_key_d;

    // One-hot LED decode straight from the counter position.
    always_comb begin
        leds = '0;
        if (!w_rest) begin
            leds = 5'(5'b00001 << pos);
        end
    end

    // Next-state, start request and judgement decisions.
    always_comb begin
        w_state_nx    = r_state;
        start         = 1'b0;
        game_over     = 1'b0;
        w_do_hit      = 1'b0;
        w_do_miss     = 1'b0;
        w_set_pressed = 1'b0;
        w_clr_pressed = 1'b0;
        w_restart     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_key_rise) begin
                    w_state_nx = S_SERVE;
                end
            end
            S_SERVE: begin
                // The request drops the same cycle the counter leaves rest.
                start = w_rest;
                if (!w_rest) begin
                    w_state_nx    = S_SWEEP;
                    w_clr_pressed = 1'b1;
                end
            end
            S_SWEEP: begin
                if (!w_rest) begin
                    if (!r_pressed && w_key_rise) begin
                        w_set_pressed = 1'b1;
                        if (pos == c_target) begin
                            w_do_hit  = 1'b1;
                        end else begin
                            w_do_miss = 1'b1;
                        end
                    end
                end else begin
                    // Sweep end: an unanswered sweep costs a life; a press
                    // at rest is never judged.
                    if (!r_pressed) begin
                        w_do_miss = 1'b1;
                        w_state_nx = (lives <= 2'd1) ? S_OVER : S_SERVE;
                    end else begin
                        w_state_nx = (lives == 2'd0) ? S_OVER : S_SERVE;
                    end
                end
            end
            S_OVER: begin
                game_over = 1'b1;
                if (w_key_rise) begin
                    w_state_nx = S_IDLE;
                    w_restart  = 1'b1;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Game state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Edge detector, press flag, pulses, score and lives.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_key_d   <= 1'b0;
            r_pressed <= 1'b0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            score     <= '0;
            lives     <= c_lives;
        end else begin
            r_key_d <= key;
            hit     <= w_do_hit;
            miss    <= w_do_miss;
            if (w_clr_pressed) begin
                r_pressed <= 1'b0;
            end else if (w_set_pressed) begin
                r_pressed <= 1'b1;
            end
            if (w_restart) begin
                score <= '0;
                lives <= c_lives;
            end else begin
                if (w_do_hit && (score != c_score_max)) begin
                    score <= score + 1'b1;
                end
                if (w_do_miss && (lives != 2'd0)) begin
                    lives <= lives - 2'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/light_judge.md
Name: light_judge

Overview:
- Downstream consumer of the 3-bit light-position counter (position 0..4 = sweep, 5 = rest).
- Decodes the position to LEDs and judges a player key press against a target position.
- Keeps score and lives.
- Drives the counter's start input, so it also closes the loop upstream.
- Runs a small game FSM: idle, serve, sweep, game over.

Parameters:
TARGET, 4, position (0..4) at which a press counts as a hit
SCORE_W, 4, score counter width; saturates at 2^SCORE_W-1
LIVES, 3, lives loaded at reset and at game restart (1..3)

Ports:
Clock  input  1  system clock
Reset  input  1  synchronous, active-high reset
pos  input  3  light position from counter; 0..4 sweep, 5 rest; 6,7 treated as 5
key  input  1  player button, already synchronized, active-high level
start  output  1  start request to counter; counter samples it on its own tick while at 5
leds  output  5  one-hot sweep display
hit  output  1  one-cycle pulse on a hit
miss  output  1  one-cycle pulse on a miss
score  output  SCORE_W  current score
lives  output  2  remaining lives
game_over  output  1  high while in OVER

Behaviour:
- Interface: one clock (Clock); Reset is synchronous and active-high.
- Reset values: state=IDLE, start=0, hit=0, miss=0, score=0, lives=LIVES, pressed=0, key_d=0, game_over=0.
- Reset asserted mid-sweep aborts the sweep with no hit/miss pulse.
- Edge detect: key_d <= key; key_rise = key & ~key_d. Holding key generates one event only.
- leds: combinational from pos. leds[pos]=1 for pos 0..4; leds=0 for pos>=5. Independent of state.
- States and transitions:
  - IDLE: start=0. key_rise -> SERVE.
  - SERVE: start=1, held until pos != 5 (the counter may take many cycles to sample it).
    - Seeing pos != 5 -> SWEEP, with pressed <= 0 and start=0 from that cycle.
    - key_rise in SERVE is ignored.
  - SWEEP, pos in 0..4, pressed=0, key_rise:
    - pressed <= 1.
    - pos==TARGET: next cycle hit=1, score <= score+1, saturating at max.
    - Otherwise: next cycle miss=1, lives <= lives-1.
  - SWEEP, pressed=1: further key_rise is ignored; at most one judgement per sweep.
  - SWEEP, pos reaches 5 (sweep end):
    - If pressed=0, miss=1 next cycle and lives decrement. key_rise in that same cycle is ignored (rest is never a hit).
    - Then: lives after any decrement == 0 -> OVER; else -> SERVE (auto re-serve, continuous play).
  - OVER: game_over=1, start=0. key_rise -> IDLE with score <= 0, lives <= LIVES.
- Latency:
  - hit/miss assert exactly 1 cycle after the judging edge (key_rise or sweep-end detection).
  - score/lives update on the same edge that raises the pulse.
- lives never underflows; a decrement at 0 cannot occur because OVER is entered first.
- Simultaneous hit judgement and sweep end cannot occur, since TARGET<=4.
- Counter pos changes while in IDLE/OVER are ignored except for leds.

Test Plan:
- Reset, then Reset=0 with pos=5, key=0 -> state IDLE, start=0, score=0, lives=3, leds=0, game_over=0.
- Serve with 4-cycle delay: key rise in IDLE -> start=1 next cycle; hold pos=5 four cycles -> start stays 1; drive pos=0 -> start=0 and leds=5'b00001.
- Hit: in SWEEP, pos=4, key 0->1 -> hit=1 for exactly one cycle next clock, score 0->1; pos=5 -> no miss.
- Early press: key rise at pos=2 -> miss pulse, lives 3->2. Key held high through pos=4 -> no hit (no new edge). pos=5 -> no second miss, back to SERVE with start=1.
- No press: three full sweeps with key=0 -> miss at each pos=5, lives 3->2->1->0, game_over=1 after the third. Then key rise -> IDLE, score=0, lives=3.
- Saturation: with SCORE_W=2, four hits -> score 1,2,3,3; hit still pulses on the fourth. Reset asserted at pos=1 mid-sweep -> all outputs return to reset values next cycle, with no pulse.
